// File: rtl/scan8_if.sv
// rtl/scan8_if.sv - host/selector-side signal bundle for the 8-digit scan controller
interface scan8_if;
  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  blank_mask;
  logic [31:0] datain_o;
  logic [2:0]  sel;
  logic [7:0]  an_n;
  logic        pending;
  logic        frame_done;

  modport master (
    output en, load, data_in, blank_mask,
    input  datain_o, sel, an_n, pending, frame_done
  );

  modport slave (
    input  en, load, data_in, blank_mask,
    output datain_o, sel, an_n, pending, frame_done
  );
endinterface

// File: rtl/scan8_ctrl.sv
// rtl/scan8_ctrl.sv - prescaled 8-digit scan driver with frame-boundary commit of a shadowed frame
module scan8_ctrl #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  scan8_if.slave bus
);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] BLANK_W  = 16'(BLANK);

  logic [15:0] prescale;
  logic [2:0]  sel_q;
  logic [31:0] frame_q;
  logic [31:0] pend_reg;
  logic        pend_q;
  logic        done_q;
  logic [7:0]  an_q;
  logic        tick;
  logic        wrap;

  assign tick = bus.en && (prescale == DIV_LAST);
  assign wrap = tick && (sel_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= 16'd0;
      sel_q    <= 3'd0;
    end else if (bus.en) begin
      prescale <= tick ? 16'd0 : prescale + 16'd1;
      if (tick) sel_q <= sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= wrap;
  end

  // The displayed frame only moves on a wrap, so a scan never mixes two frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= 32'd0;
      pend_reg <= 32'd0;
      pend_q   <= 1'b0;
    end else if (wrap) begin
      if (bus.load) begin
        frame_q <= bus.data_in;
        pend_q  <= 1'b0;
      end else if (pend_q) begin
        frame_q <= pend_reg;
        pend_q  <= 1'b0;
      end
    end else if (bus.load) begin
      pend_reg <= bus.data_in;
      pend_q   <= 1'b1;
    end
  end

  // Blank window at the start of each slot hides the sel/datain transition.
  always_comb begin
    an_q = 8'hFF;
    if (bus.en && (prescale >= BLANK_W) && !bus.blank_mask[sel_q])
      an_q[sel_q] = 1'b0;
  end

  assign bus.datain_o   = frame_q;
  assign bus.sel        = sel_q;
  assign bus.an_n       = an_q;
  assign bus.pending    = pend_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_scan8_ctrl.sv
// tb/tb_scan8_ctrl.sv - randomized bench for scan8_ctrl against a slot-arithmetic reference model
module tb_scan8_ctrl;
  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan8_if bus();
  scan8_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position in the scan is derived from the count of enabled cycles.
  int          m_ecount;
  logic [31:0] m_disp;
  logic [31:0] m_pdata;
  logic        m_pend;
  logic        m_fd;

  function automatic logic [2:0] m_sel();
    return 3'((m_ecount / DIV) % 8);
  endfunction

  function automatic logic [7:0] m_an();
    int ps;
    int s;
    ps = m_ecount % DIV;
    s  = (m_ecount / DIV) % 8;
    if (!bus.en || ps < BLANK || bus.blank_mask[s]) return 8'hFF;
    return ~(8'h01 << s);
  endfunction

  task automatic model_reset();
    m_ecount = 0;
    m_disp   = 32'd0;
    m_pdata  = 32'd0;
    m_pend   = 1'b0;
    m_fd     = 1'b0;
  endtask

  task automatic step();
    bit wr;
    wr   = bus.en && ((m_ecount % (8 * DIV)) == (8 * DIV - 1));
    m_fd = wr;
    if (wr) begin
      if (bus.load) begin
        m_disp = bus.data_in;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_disp = m_pdata;
        m_pend = 1'b0;
      end
    end else if (bus.load) begin
      m_pdata = bus.data_in;
      m_pend  = 1'b1;
    end
    if (bus.en) m_ecount++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.en         = 1'b0;
    bus.load       = 1'b0;
    bus.data_in    = 32'd0;
    bus.blank_mask = 8'd0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) step();
    bus.load = 1'b1; bus.data_in = 32'hCAFEF00D;
    step();
    bus.load = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.sel !== 3'd0 || bus.datain_o !== 32'd0 || bus.pending !== 1'b0 ||
        bus.frame_done !== 1'b0 || bus.an_n !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_state sel=%0d datain=%h pend=%b fd=%b an=%h required 0/0/0/0/ff",
               bus.sel, bus.datain_o, bus.pending, bus.frame_done, bus.an_n);
    end
    do_reset();
  endtask

  task automatic test_scan();
    int pulses;
    pulses = 0;
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      n_tests++;
      if (bus.sel !== m_sel() || bus.an_n !== m_an() || bus.frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL scan cyc=%0d sel=%0d/%0d an=%h/%h fd=%b/%b (got/required)",
                 i, bus.sel, m_sel(), bus.an_n, m_an(), bus.frame_done, m_fd);
      end
      if (bus.frame_done) pulses++;
      step();
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL scan_frame_done_count got=%0d required=1", pulses);
    end
  endtask

  task automatic test_load();
    bit seen;
    seen = 1'b0;
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.load = 1'b1; bus.data_in = 32'h76543210;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      n_tests++;
      if (bus.frame_done) begin
        seen = 1'b1;
        if (bus.datain_o !== 32'h76543210 || bus.pending !== 1'b0) begin
          n_fail++;
          $display("FAIL load_commit datain=%h pend=%b required 76543210/0", bus.datain_o, bus.pending);
        end
      end else if (bus.datain_o !== 32'd0 || bus.pending !== 1'b1) begin
        n_fail++;
        $display("FAIL load_wait cyc=%0d datain=%h pend=%b required 0/1", i, bus.datain_o, bus.pending);
      end
      if (!seen) step();
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL load_timeout no frame_done within bound");
    end
  endtask

  task automatic test_double_load();
    bit seen;
    seen = 1'b0;
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.load = 1'b1; bus.data_in = 32'h11111111; step();
    bus.load = 1'b0; step(); step();
    bus.load = 1'b1; bus.data_in = 32'hAAAAAAAA; step();
    bus.load = 1'b0; bus.data_in = 32'h0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (bus.frame_done) seen = 1'b1;
      else step();
    end
    n_tests++;
    if (!seen || bus.datain_o !== 32'hAAAAAAAA || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL double_load seen=%b datain=%h pend=%b required 1/aaaaaaaa/0",
               seen, bus.datain_o, bus.pending);
    end
  endtask

  task automatic test_wrap_load();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.load = 1'b1; bus.data_in = 32'h12345678; step();
    bus.load = 1'b0;
    for (int i = 0; i < 40 && (m_ecount % (8 * DIV)) != (8 * DIV - 1); i++) step();
    bus.load = 1'b1; bus.data_in = 32'hDEADBEEF;
    step();
    bus.load = 1'b0;
    #1;
    n_tests++;
    if (bus.datain_o !== 32'hDEADBEEF || bus.pending !== 1'b0 || bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_load datain=%h pend=%b fd=%b required deadbeef/0/1",
               bus.datain_o, bus.pending, bus.frame_done);
    end
  endtask

  task automatic test_mask();
    logic [7:0] req;
    do_reset();
    bus.en = 1'b1;
    bus.blank_mask = 8'h0F;
    for (int i = 0; i < 32; i++) begin
      #1;
      req = m_an();
      n_tests++;
      if (bus.an_n !== req || (i < 16 && bus.an_n !== 8'hFF)) begin
        n_fail++;
        $display("FAIL mask cyc=%0d an=%h required=%h", i, bus.an_n, (i < 16) ? 8'hFF : req);
      end
      step();
    end
    bus.blank_mask = 8'h00;
  endtask

  task automatic test_en_hold();
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 64 && !(m_sel() == 3'd5 && (m_ecount % DIV) == 2); i++) step();
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin bus.load = 1'b1; bus.data_in = 32'h0BADF00D; end
      if (i == 5) bus.load = 1'b0;
      #1;
      n_tests++;
      if (bus.sel !== 3'd5 || bus.an_n !== 8'hFF) begin
        n_fail++;
        $display("FAIL en_hold cyc=%0d sel=%0d an=%h required 5/ff", i, bus.sel, bus.an_n);
      end
      step();
    end
    #1;
    n_tests++;
    if (bus.pending !== 1'b1 || bus.datain_o !== 32'd0) begin
      n_fail++;
      $display("FAIL en_hold_load pend=%b datain=%h required 1/0", bus.pending, bus.datain_o);
    end
    bus.en = 1'b1;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.sel !== 3'd0 || bus.datain_o !== 32'd0 || bus.pending !== 1'b0 ||
        bus.frame_done !== 1'b0 || bus.an_n !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_reset sel=%0d datain=%h pend=%b fd=%b an=%h required 0/0/0/0/ff",
               bus.sel, bus.datain_o, bus.pending, bus.frame_done, bus.an_n);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.en         = ($urandom % 4) != 0;
      bus.load       = ($urandom % 8) == 0;
      bus.data_in    = $urandom;
      bus.blank_mask = (($urandom % 4) == 0) ? 8'($urandom) : 8'h00;
      #1;
      n_tests++;
      if (bus.sel !== m_sel() || bus.an_n !== m_an() || bus.frame_done !== m_fd ||
          bus.pending !== m_pend || bus.datain_o !== m_disp || $countones(~bus.an_n) > 1) begin
        n_fail++;
        $display("FAIL random cyc=%0d sel=%0d/%0d an=%h/%h fd=%b/%b pend=%b/%b datain=%h/%h (got/required)",
                 i, bus.sel, m_sel(), bus.an_n, m_an(), bus.frame_done, m_fd,
                 bus.pending, m_pend, bus.datain_o, m_disp);
      end
      step();
    end
    bus.en = 1'b0;
    bus.load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.data_in = 32'd0;
    bus.blank_mask = 8'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_scan();
    test_load();
    test_double_load();
    test_wrap_load();
    test_mask();
    test_en_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scan8_ctrl.md
Name: scan8_ctrl

Overview:
- Upstream driver for the 8-way 4-bit nibble selector.
- Holds a 32-bit frame of eight nibbles in a tear-free shadow register and presents it on `datain_o`.
- Steps `sel` through 0..7 at a prescaled rate and produces matching active-low digit enables with an anti-ghosting blank window.
- Accepts new frames from the host via a load pulse; the frame is committed only at a frame boundary.

Parameters:
- `DIV`, 50000: clk cycles per digit slot; legal range 2..65535.
- `BLANK`, 8: cycles at the start of each slot with all digits off; must be < `DIV`.

Ports:
- `clk`  input  1  system clock, rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `en`  input  1  scan enable
- `load`  input  1  single-cycle pulse; capture `data_in`
- `data_in`  input  32  new frame; nibble k in [4k+3:4k]
- `blank_mask`  input  8  bit k=1 forces digit k dark
- `datain_o`  output  32  committed frame, to selector datain
- `sel`  output  3  current digit index, to selector sel
- `an_n`  output  8  active-low digit enables
- `pending`  output  1  a loaded frame awaits commit
- `frame_done`  output  1  one-cycle pulse on 7->0 wrap

Behaviour:
- Reset (async, `rst_n`=0): `prescale`=0, `sel`=0, `datain_o`=0, `pend_reg`=0, `pending`=0, `frame_done`=0, `an_n`=8'hFF. Takes effect immediately, including mid-slot or mid-load; a pending frame is discarded.
- Prescaler (16-bit):
  - When `en`=1, counts 0..`DIV`-1 and wraps. `tick` = (`prescale`==`DIV`-1) && `en`.
  - When `en`=0, prescaler and `sel` hold their values.
- Sel:
  - On `tick`, `sel` <= `sel`+1 mod 8.
  - `wrap` = `tick` && `sel`==7.
  - `frame_done` is registered: 1 for exactly the cycle after `wrap`, else 0.
- `an_n` (combinational from registers and inputs):
  - All ones if `en`=0, or `prescale` < `BLANK`, or `blank_mask[sel]`=1.
  - Otherwise, bit `sel` is 0 and all other bits are 1.
  - At most one bit is ever 0.
- Load and commit:
  - `load`=1 without `wrap`: `pend_reg` <= `data_in`, `pending` <= 1. A later load before commit overwrites `pend_reg`; last one wins.
  - `wrap` with `pending`=1 and `load`=0: `datain_o` <= `pend_reg`, `pending` <= 0.
  - `wrap` and `load` in the same cycle: `datain_o` <= `data_in` directly, `pending` <= 0; the older pending frame is dropped.
  - `wrap` with `pending`=0 and `load`=0: `datain_o` holds.
  - Net effect: `datain_o` changes only in the cycle after a `wrap`, so a frame is never displayed partially old and partially new.
  - `load` while `en`=0 is accepted. Commit waits for the next `wrap` after `en` returns to 1.
- Latency: `load` to visible at `datain_o` is at most 8·`DIV` cycles and at least 1 cycle (load coincident with wrap).
- Width rules:
  - `sel` wraps naturally at 3 bits.
  - The prescaler compare uses `DIV`-1 at 16 bits; `DIV`=1 is illegal.
  - No arithmetic on data; it is pass-through.

Test Plan (`DIV`=4, `BLANK`=1):
1. Reset then `en`=1, `blank_mask`=0 for 40 cycles. Required:
   - `sel` steps 0,1,...,7,0 every 4 cycles.
   - `an_n`=8'hFF on the first cycle of each slot, then 8'hFE, 8'hFD, ... 8'h7F.
   - `frame_done` pulses once per 32 cycles.
2. `load` with `data_in`=32'h76543210 mid-frame. Required:
   - `pending`=1 and `datain_o` stays 0 until the cycle after the 7->0 wrap.
   - Then `datain_o`=32'h76543210 and `pending`=0.
3. Two loads in one frame: 32'h11111111 then 32'hAAAAAAAA. Required: only 32'hAAAAAAAA is committed at the wrap.
4. `load` asserted exactly on the wrap cycle with 32'hDEADBEEF while an older frame is pending. Required: `datain_o`=32'hDEADBEEF next cycle and `pending`=0.
5. `blank_mask`=8'h0F. Required: `an_n`=8'hFF throughout slots 0-3; normal enables in slots 4-7.
6. Drop `en` at `sel`=5 for 20 cycles, then assert `rst_n`=0 mid-slot. Required:
   - While `en`=0, `sel` holds 5 and `an_n`=8'hFF.
   - On reset, all outputs return immediately to reset values (async, no clock edge needed).
